// File: rtl/serdes_pkg.sv
// -----------------------------------------------------------------------------
// serdes_pkg
// Shared definitions for the serializer/deserializer family (PISO, SIPO and
// the framers built on top of them).
//   serdes_state_t : two-state FSM encoding used by the shifting stages
//   clog2()        : elaboration-time counter width helper
// -----------------------------------------------------------------------------
package serdes_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } serdes_state_t;

  // Number of bits needed to count 0..value-1. Returns at least 1 so that a
  // counter declared with this width is always legal.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// -----------------------------------------------------------------------------
// piso_serializer
// Parallel-in / serial-out stage feeding the SIPO deserializer. A WIDTH-bit
// word is accepted through a valid/ready handshake and sent one bit per clock
// (MSB first when MSB_FIRST=1, LSB first otherwise). Consecutive words can be
// sent with no gap: a new word is accepted on the edge that ends the frame.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   load_valid   load_data holds a word to send
//   load_data    word to serialize (sampled only on an accepting edge)
//   load_ready   combinational: a word can be accepted this cycle
//   serial_out   registered serial bit
//   serial_valid serial_out carries a frame bit
//   frame_start  pulse on the first bit of a frame
//   frame_done   pulse on the last bit of a frame
//   busy         high while a frame is in flight
// -----------------------------------------------------------------------------
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  serdes_state_t    state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             serial_out_reg;
  logic             serial_valid_reg;
  logic             frame_start_reg;
  logic             frame_done_reg;
  logic             busy_reg;

  logic             at_last;
  logic             xfer;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] shreg_shifted;
  logic             load_head;
  logic             shifted_head;

  assign at_last    = (state_reg == ST_SHIFT) && (cnt_reg == CNT_LAST);
  assign load_ready = (state_reg == ST_IDLE) || at_last;
  assign xfer       = load_valid && load_ready;
  assign cnt_inc    = cnt_reg + CNT_W'(1);

  // Head bit is the one currently on the wire; the shift moves the next bit
  // into the head position and zero-fills from the far end.
  always_comb begin
    if (MSB_FIRST) begin
      shreg_shifted = {shreg_reg[WIDTH-2:0], 1'b0};
      load_head     = load_data[WIDTH-1];
      shifted_head  = shreg_reg[WIDTH-2];
    end else begin
      shreg_shifted = {1'b0, shreg_reg[WIDTH-1:1]};
      load_head     = load_data[0];
      shifted_head  = shreg_reg[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= ST_IDLE;
      shreg_reg        <= '0;
      cnt_reg          <= '0;
      serial_out_reg   <= 1'b0;
      serial_valid_reg <= 1'b0;
      frame_start_reg  <= 1'b0;
      frame_done_reg   <= 1'b0;
      busy_reg         <= 1'b0;
    end else if (xfer) begin
      // Covers both a fresh start from IDLE and a back-to-back reload on the
      // last bit of the previous frame.
      state_reg        <= ST_SHIFT;
      shreg_reg        <= load_data;
      cnt_reg          <= '0;
      serial_out_reg   <= load_head;
      serial_valid_reg <= 1'b1;
      frame_start_reg  <= 1'b1;
      frame_done_reg   <= 1'b0;
      busy_reg         <= 1'b1;
    end else if (state_reg == ST_SHIFT) begin
      if (at_last) begin
        state_reg        <= ST_IDLE;
        shreg_reg        <= '0;
        cnt_reg          <= '0;
        serial_out_reg   <= 1'b0;
        serial_valid_reg <= 1'b0;
        frame_start_reg  <= 1'b0;
        frame_done_reg   <= 1'b0;
        busy_reg         <= 1'b0;
      end else begin
        shreg_reg       <= shreg_shifted;
        cnt_reg         <= cnt_inc;
        serial_out_reg  <= shifted_head;
        frame_start_reg <= 1'b0;
        frame_done_reg  <= (cnt_inc == CNT_LAST);
      end
    end
  end

  assign serial_out   = serial_out_reg;
  assign serial_valid = serial_valid_reg;
  assign frame_start  = frame_start_reg;
  assign frame_done   = frame_done_reg;
  assign busy         = busy_reg;

endmodule
